// File: rtl/tcp_server_types.sv
// Shared TCP server types: event classes, flag bit positions and header limits.
// Used by the segment classifier and the server FSM.
package tcp_server_types;

    typedef enum logic [2:0] {
        EVT_INVALID = 3'd0,
        EVT_SYN     = 3'd1,
        EVT_SYN_ACK = 3'd2,
        EVT_ACK     = 3'd3,
        EVT_FIN     = 3'd4,
        EVT_RST     = 3'd5,
        EVT_DATA    = 3'd6
    } tcp_evt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_OPT,
        ST_PAYLOAD,
        ST_EMIT,
        ST_DROP
    } cls_state_t;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam int FLAG_URG = 5;

    localparam logic [3:0] MIN_DOFF = 4'd5;

    // Fixed-priority event class for a well-formed segment
    function automatic tcp_evt_t classify(input logic [5:0] fl, input logic [15:0] len);
        if (fl[FLAG_RST])                    return EVT_RST;
        if (fl[FLAG_SYN] && fl[FLAG_ACK])    return EVT_SYN_ACK;
        if (fl[FLAG_SYN])                    return EVT_SYN;
        if (fl[FLAG_FIN])                    return EVT_FIN;
        if (len != 16'd0)                    return EVT_DATA;
        if (fl[FLAG_ACK])                    return EVT_ACK;
        return EVT_INVALID;
    endfunction

endpackage

// File: rtl/tcp_segment_classifier.sv
// Parses a byte-serial TCP segment, filters on destination port and emits
// one classified event per accepted segment through a valid/ready handshake.
module tcp_segment_classifier
    import tcp_server_types::*;
#(
    parameter logic [15:0] LOCAL_PORT     = 16'd80,
    parameter logic [15:0] DROP_CNT_RESET = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [2:0]  evt_kind,
    output logic [31:0] evt_seq,
    output logic [31:0] evt_ack,
    output logic [15:0] evt_payload_len,
    output logic [15:0] drop_cnt
);

    cls_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] dport_q, dport_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] ack_q, ack_d;
    logic [3:0]  doff_q, doff_d;
    logic [5:0]  flags_q, flags_d;
    logic [15:0] plen_q, plen_d;
    tcp_evt_t    evt_kind_q, evt_kind_d;
    logic [31:0] evt_seq_q, evt_seq_d;
    logic [31:0] evt_ack_q, evt_ack_d;
    logic [15:0] evt_len_q, evt_len_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        rdy_q, rdy_d;

    logic        accept;
    logic        done;
    logic        invalid;
    logic [5:0]  opt_end;

    assign accept  = in_valid && rdy_q;
    assign opt_end = {doff_q, 2'b00} - 6'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dport_d    = dport_q;
        seq_d      = seq_q;
        ack_d      = ack_q;
        doff_d     = doff_q;
        flags_d    = flags_q;
        plen_d     = plen_q;
        evt_kind_d = evt_kind_q;
        evt_seq_d  = evt_seq_q;
        evt_ack_d  = evt_ack_q;
        evt_len_d  = evt_len_q;
        drop_cnt_d = drop_cnt_q;
        done       = 1'b0;
        invalid    = 1'b0;

        case (state_q)
            ST_IDLE: if (accept) begin
                dport_d = '0;
                seq_d   = '0;
                ack_d   = '0;
                doff_d  = '0;
                flags_d = '0;
                plen_d  = '0;
                cnt_d   = 6'd1;
                if (in_last) begin
                    done    = 1'b1;
                    invalid = 1'b1;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: if (accept) begin
                cnt_d = cnt_q + 6'd1;
                case (cnt_q)
                    6'd2:  dport_d[15:8] = in_data;
                    6'd3:  dport_d[7:0]  = in_data;
                    6'd4:  seq_d[31:24]  = in_data;
                    6'd5:  seq_d[23:16]  = in_data;
                    6'd6:  seq_d[15:8]   = in_data;
                    6'd7:  seq_d[7:0]    = in_data;
                    6'd8:  ack_d[31:24]  = in_data;
                    6'd9:  ack_d[23:16]  = in_data;
                    6'd10: ack_d[15:8]   = in_data;
                    6'd11: ack_d[7:0]    = in_data;
                    6'd12: doff_d        = in_data[7:4];
                    6'd13: flags_d       = in_data[5:0];
                    default: ;
                endcase
                if (in_last) begin
                    done    = 1'b1;
                    invalid = (cnt_q != 6'd19) || (doff_q < MIN_DOFF);
                end else if (cnt_q == 6'd19) begin
                    state_d = (doff_q > MIN_DOFF) ? ST_OPT : ST_PAYLOAD;
                end
            end
            ST_OPT: if (accept) begin
                cnt_d = cnt_q + 6'd1;
                if (in_last) begin
                    done    = 1'b1;
                    invalid = (cnt_q != opt_end);
                end else if (cnt_q == opt_end) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: if (accept) begin
                if (plen_q != 16'hFFFF) plen_d = plen_q + 16'd1;
                if (in_last) begin
                    done    = 1'b1;
                    invalid = (doff_q < MIN_DOFF);
                end
            end
            ST_EMIT: if (evt_ready) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            ST_DROP: begin
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Malformed segments are always reported, never silently dropped
        if (done) begin
            if (invalid) begin
                evt_kind_d = EVT_INVALID;
                evt_seq_d  = seq_d;
                evt_ack_d  = ack_d;
                evt_len_d  = '0;
                state_d    = ST_EMIT;
            end else if (dport_d != LOCAL_PORT) begin
                state_d = ST_DROP;
            end else begin
                evt_kind_d = classify(flags_d, plen_d);
                evt_seq_d  = seq_d;
                evt_ack_d  = ack_d;
                evt_len_d  = plen_d;
                state_d    = ST_EMIT;
            end
        end

        rdy_d = (state_d != ST_EMIT) && (state_d != ST_DROP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dport_q    <= '0;
            seq_q      <= '0;
            ack_q      <= '0;
            doff_q     <= '0;
            flags_q    <= '0;
            plen_q     <= '0;
            evt_kind_q <= EVT_INVALID;
            evt_seq_q  <= '0;
            evt_ack_q  <= '0;
            evt_len_q  <= '0;
            drop_cnt_q <= DROP_CNT_RESET;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dport_q    <= dport_d;
            seq_q      <= seq_d;
            ack_q      <= ack_d;
            doff_q     <= doff_d;
            flags_q    <= flags_d;
            plen_q     <= plen_d;
            evt_kind_q <= evt_kind_d;
            evt_seq_q  <= evt_seq_d;
            evt_ack_q  <= evt_ack_d;
            evt_len_q  <= evt_len_d;
            drop_cnt_q <= drop_cnt_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_ready        = rdy_q;
    assign evt_valid       = (state_q == ST_EMIT);
    assign evt_kind        = evt_kind_q;
    assign evt_seq         = evt_seq_q;
    assign evt_ack         = evt_ack_q;
    assign evt_payload_len = evt_len_q;
    assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_tcp_segment_classifier.sv
// Self-checking bench for tcp_segment_classifier: vector table plus
// scoreboard, with stall, drop-saturation and mid-segment reset sequences.
module tb_tcp_segment_classifier;
    import tcp_server_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic        evt_valid, evt_ready;
    logic [2:0]  evt_kind;
    logic [31:0] evt_seq, evt_ack;
    logic [15:0] evt_payload_len, drop_cnt;

    logic        in_ready2, evt_valid2;
    logic [2:0]  evt_kind2;
    logic [31:0] evt_seq2, evt_ack2;
    logic [15:0] evt_len2, drop_cnt2;

    always #5 clk = ~clk;

    tcp_segment_classifier dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_kind(evt_kind), .evt_seq(evt_seq),
        .evt_ack(evt_ack), .evt_payload_len(evt_payload_len), .drop_cnt(drop_cnt)
    );

    // Second instance with a saturated drop counter preset
    tcp_segment_classifier #(.DROP_CNT_RESET(16'hFFFF)) dut_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready2), .evt_valid(evt_valid2),
        .evt_ready(evt_ready), .evt_kind(evt_kind2), .evt_seq(evt_seq2),
        .evt_ack(evt_ack2), .evt_payload_len(evt_len2), .drop_cnt(drop_cnt2)
    );

    typedef struct {
        logic [15:0] dport;
        logic [7:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [3:0]  doff;
        int          npay;
        int          last_at;
        tcp_evt_t    kind;
        logic [15:0] len;
        bit          drop;
    } vec_t;

    typedef struct {
        tcp_evt_t    kind;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] len;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   n_chk = 0;
    int   n_pass = 0;
    int   exp_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(logic [15:0] dp, logic [7:0] fl, logic [31:0] sq,
                                logic [31:0] ak, logic [3:0] doff, int npay, int last_at,
                                tcp_evt_t kind, logic [15:0] len, bit drop);
        vec_t v;
        v.dport = dp; v.flags = fl; v.seq = sq; v.ack = ak; v.doff = doff;
        v.npay = npay; v.last_at = last_at; v.kind = kind; v.len = len; v.drop = drop;
        return v;
    endfunction

    function automatic int seg_total(vec_t v);
        int hl;
        hl = (v.doff >= 4'd5) ? int'(v.doff) * 4 : 20;
        return (v.last_at >= 0) ? v.last_at + 1 : hl + v.npay;
    endfunction

    function automatic logic [7:0] seg_byte(vec_t v, int i);
        if (i >= seg_total(v)) return 8'h00;
        case (i)
            0: return 8'h12;
            1: return 8'h34;
            2: return v.dport[15:8];
            3: return v.dport[7:0];
            4: return v.seq[31:24];
            5: return v.seq[23:16];
            6: return v.seq[15:8];
            7: return v.seq[7:0];
            8: return v.ack[31:24];
            9: return v.ack[23:16];
            10: return v.ack[15:8];
            11: return v.ack[7:0];
            12: return {v.doff, 4'h0};
            13: return v.flags;
            default: return 8'(i * 3 + 1);
        endcase
    endfunction

    function automatic exp_t expect_of(vec_t v);
        exp_t e;
        e.kind = v.kind;
        e.len  = v.len;
        e.seq  = {seg_byte(v, 4), seg_byte(v, 5), seg_byte(v, 6), seg_byte(v, 7)};
        e.ack  = {seg_byte(v, 8), seg_byte(v, 9), seg_byte(v, 10), seg_byte(v, 11)};
        return e;
    endfunction

    task automatic put(input logic [7:0] b, input logic l);
        int n;
        @(negedge clk);
        in_data = b; in_valid = 1'b1; in_last = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_chk++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    endtask

    task automatic send(input vec_t v);
        int t;
        t = seg_total(v);
        for (int i = 0; i < t; i++) put(seg_byte(v, i), (i == t - 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
    endtask

    // Scoreboard consumer: one pop per completed handshake
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected event: got kind %0d expected none", evt_kind);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("evt_kind", 32'(evt_kind), 32'(e.kind));
                chk("evt_seq", evt_seq, e.seq);
                chk("evt_ack", evt_ack, e.ack);
                chk("evt_len", 32'(evt_payload_len), 32'(e.len));
            end
        end
    end

    initial begin
        vec_t v;
        exp_t e;
        vecs[0]  = mk(16'd80, 8'h02, 32'h11223344, 32'h0, 4'd5, 0, -1, EVT_SYN, 16'd0, 0);
        vecs[1]  = mk(16'd80, 8'h18, 32'hA0A1A2A3, 32'hCAFEBABE, 4'd6, 10, -1, EVT_DATA, 16'd10, 0);
        vecs[2]  = mk(16'd80, 8'h14, 32'h00000010, 32'h55667788, 4'd5, 0, -1, EVT_RST, 16'd0, 0);
        vecs[3]  = mk(16'd80, 8'h12, 32'h01020304, 32'h11111111, 4'd5, 0, -1, EVT_SYN_ACK, 16'd0, 0);
        vecs[4]  = mk(16'd80, 8'h11, 32'hDEADBEEF, 32'h22222222, 4'd5, 0, -1, EVT_FIN, 16'd0, 0);
        vecs[5]  = mk(16'd80, 8'h10, 32'h33333333, 32'h44444444, 4'd5, 0, -1, EVT_ACK, 16'd0, 0);
        vecs[6]  = mk(16'd80, 8'h10, 32'h55555555, 32'h66666666, 4'd5, 3, -1, EVT_DATA, 16'd3, 0);
        vecs[7]  = mk(16'd80, 8'h08, 32'h77777777, 32'h88888888, 4'd5, 0, -1, EVT_INVALID, 16'd0, 0);
        vecs[8]  = mk(16'd81, 8'h02, 32'h99999999, 32'h0, 4'd5, 0, -1, EVT_INVALID, 16'd0, 1);
        vecs[9]  = mk(16'd81, 8'h02, 32'hABCDEF01, 32'h12345678, 4'd5, 0, 9, EVT_INVALID, 16'd0, 0);
        vecs[10] = mk(16'd80, 8'h10, 32'h0BADF00D, 32'h10203040, 4'd4, 2, -1, EVT_INVALID, 16'd0, 0);
        vecs[11] = mk(16'd80, 8'h10, 32'h13572468, 32'h24681357, 4'd8, 4, 25, EVT_INVALID, 16'd0, 0);
        vecs[12] = mk(16'd80, 8'h14, 32'h0000FFFF, 32'hFFFF0000, 4'd5, 5, -1, EVT_RST, 16'd5, 0);
        vecs[13] = mk(16'd80, 8'h10, 32'h76543210, 32'h89ABCDEF, 4'd7, 0, 27, EVT_ACK, 16'd0, 0);

        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst evt_valid", 32'(evt_valid), 32'd0);
        chk("rst evt_kind", 32'(evt_kind), 32'(EVT_INVALID));
        chk("rst evt_seq", evt_seq, 32'd0);
        chk("rst evt_ack", evt_ack, 32'd0);
        chk("rst evt_len", 32'(evt_payload_len), 32'd0);
        chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst drop_cnt preset", 32'(drop_cnt2), 32'hFFFF);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after rst", 32'(in_ready), 32'd1);

        for (int k = 0; k < 14; k++) begin
            v = vecs[k];
            if (!v.drop) sb.push_back(expect_of(v));
            else exp_drop++;
            send(v);
            @(negedge clk);
            chk($sformatf("v%0d evt_valid latency", k), 32'(evt_valid), v.drop ? 32'd0 : 32'd1);
            in_valid = 1'b0; in_last = 1'b0;
            drain();
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d drop_cnt", k), 32'(drop_cnt), 32'(exp_drop));
            chk($sformatf("v%0d drop_cnt preset", k), 32'(drop_cnt2), 32'hFFFF);
        end

        // Consumer stall on a truncated segment
        evt_ready = 1'b0;
        v = mk(16'd80, 8'h02, 32'hFEEDFACE, 32'hC0DE1234, 4'd5, 0, 9, EVT_INVALID, 16'd0, 0);
        e = expect_of(v);
        sb.push_back(e);
        send(v);
        idle_in();
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            chk("stall evt_valid", 32'(evt_valid), 32'd1);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall evt_kind", 32'(evt_kind), 32'(EVT_INVALID));
            chk("stall evt_seq", evt_seq, e.seq);
            chk("stall evt_ack", evt_ack, e.ack);
            chk("stall evt_len", 32'(evt_payload_len), 32'd0);
        end
        @(posedge clk);
        #1 evt_ready = 1'b1;
        drain();

        // Reset mid-segment, then a clean SYN
        v = vecs[0];
        for (int i = 0; i < 7; i++) put(seg_byte(v, i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst in_ready", 32'(in_ready), 32'd0);
        chk("mid rst evt_valid", 32'(evt_valid), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid rst no event", 32'(evt_valid), 32'd0);
        sb.push_back(expect_of(v));
        send(v);
        @(negedge clk);
        chk("post rst evt_valid", 32'(evt_valid), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tcp_segment_classifier.md
TCP_SEGMENT_CLASSIFIER -- requirements
Module: tcp_segment_classifier

Interface
REQ-001 SHALL have parameter LOCAL_PORT, default 16'd80, giving the destination port accepted; segments to any other port are dropped.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_data, input, 8, TCP segment byte, header first, network byte order.
REQ-005 SHALL have ports in_valid (input, 1, byte present), in_last (input, 1, final byte of segment) and in_ready (output, 1, byte accepted when in_valid && in_ready).
REQ-006 SHALL have ports evt_valid (output, 1, event present) and evt_ready (input, 1, consumer takes the event when evt_valid && evt_ready).
REQ-007 SHALL have port evt_kind, output, 3, event class (tcp_evt_t).
REQ-008 SHALL have ports evt_seq (output, 32, sequence number) and evt_ack (output, 32, acknowledgement number).
REQ-009 SHALL have port evt_payload_len, output, 16, payload byte count.
REQ-010 SHALL have port drop_cnt, output, 16, count of segments dropped for port mismatch, saturating.

Function
REQ-011 SHALL run FSM states IDLE, HDR, OPT, PAYLOAD, EMIT, DROP.
REQ-012 SHALL use a byte counter, 0 at segment start, to place bytes: 2-3 dst port; 4-7 seq; 8-11 ack; 12[7:4] data offset; 13[5:0] flags URG,ACK,PSH,RST,SYN,FIN. Bytes 0-1 and 14-19 are ignored.
REQ-013 SHALL transition IDLE->HDR on the first accepted byte, which is byte 0.
REQ-014 SHALL transition HDR->OPT after byte 19 when data offset >5, and HDR->PAYLOAD after byte 19 when data offset ==5.
REQ-015 SHALL transition OPT->PAYLOAD after byte (offset*4-1).
REQ-016 SHALL count every PAYLOAD byte into the payload length, saturating at 16'hFFFF.
REQ-017 SHALL transition to EMIT on an accepted in_last in HDR, OPT or PAYLOAD, or to DROP instead when the dst port differs from LOCAL_PORT.
REQ-018 SHALL raise evt_valid the cycle after in_last is accepted, i.e. 1-cycle latency.
REQ-019 SHALL assign evt_kind with fixed priority: RST > SYN_ACK (SYN&ACK) > SYN > FIN > DATA (payload>0) > ACK > INVALID.
REQ-020 SHALL emit INVALID with payload_len 0 when the segment is truncated (in_last before byte 19) or data offset <5; a truncated segment is never dropped, even if the port is unchecked.
REQ-021 SHALL hold in_ready low in EMIT and DROP and high in all other states.
REQ-022 SHALL hold evt_kind, evt_seq, evt_ack and evt_payload_len stable while evt_valid && !evt_ready.
REQ-023 SHALL go EMIT->IDLE on the handshake; back-to-back segments lose one cycle per event minimum.
REQ-024 SHALL increment drop_cnt in DROP (saturating at 16'hFFFF) and return to IDLE after one cycle with no event.
REQ-025 SHALL, when in_last arrives in OPT before the option bytes end, treat the segment as INVALID.

Reset
REQ-026 SHALL, while rst is high, force state IDLE, byte counter 0, evt_valid 0, evt_kind INVALID, evt_seq/evt_ack/evt_payload_len 0, drop_cnt 0, in_ready 0; in_ready rises in the first cycle after release.
REQ-027 SHALL discard a segment in progress when rst asserts, producing no event; the stream resumes at a fresh byte 0.

Structure
REQ-028 SHALL place tcp_evt_t (INVALID, SYN, SYN_ACK, ACK, FIN, RST, DATA), flag bit indices and MIN_DOFF=5 in shared package tcp_server_types, used also by the server FSM.
REQ-029 SHALL be a single module; no sub-module is required.

Verification
REQ-030 SHALL cover: 20-byte header, dport 80, flags 0x02, seq 0x11223344, last at byte 19 -> SYN, seq 0x11223344, len 0, evt_valid 1 cycle after last.
REQ-031 SHALL cover: offset 6, flags 0x18, 4 option bytes, 10 payload bytes -> DATA, len 10, ack field passed unchanged.
REQ-032 SHALL cover: flags 0x14 (RST|ACK) -> RST; flags 0x12 -> SYN_ACK; flags 0x11 -> FIN.
REQ-033 SHALL cover: dport 81 -> no event, drop_cnt 0->1; preset 0xFFFF stays 0xFFFF.
REQ-034 SHALL cover: in_last at byte 9 -> INVALID, len 0; evt_ready held low 5 cycles -> outputs stable, in_ready 0 throughout.
REQ-035 SHALL cover: rst pulse at byte 7 of a segment -> no event; the next full SYN segment classified correctly.
